// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A-B using one full-subtractor slice.
// Operands are latched on the accepting edge and consumed LSB first,
// one bit per clock, so a result takes WIDTH cycles in RUN plus one
// cycle in DONE.
//
// Handshake: start is sampled only in IDLE; the edge that sees start=1
// latches A/B and raises busy for exactly WIDTH cycles. done is a
// one-cycle pulse that follows, and Diff/Bout/Zero become valid on the
// same edge that raises done. There is no back-pressure: the result
// stays on Diff/Bout/Zero until the next completion overwrites it.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Zero
);

    // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             bor;
    logic [CW-1:0]    cnt;

    logic             d_bit;
    logic             bor_nxt;
    logic             last_bit;
    logic [WIDTH-1:0] r_nxt;

    // Full-subtractor slice on the current LSBs and the next result word
    always_comb begin
        d_bit    = a_sr[0] ^ b_sr[0] ^ bor;
        bor_nxt  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bor);
        r_nxt    = {d_bit, r_sr[WIDTH-1:1]};
        last_bit = (cnt == LAST);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start only matters in IDLE, DONE lasts one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded straight from the state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: latch on accept, shift in RUN, publish only on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            r_sr <= '0;
            bor  <= 1'b0;
            cnt  <= '0;
            Diff <= '0;
            Bout <= 1'b0;
            Zero <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= A;
                        b_sr <= B;
                        r_sr <= '0;
                        bor  <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    r_sr <= r_nxt;
                    bor  <= bor_nxt;
                    cnt  <= cnt + CW'(1);
                    if (last_bit) begin
                        Diff <= r_nxt;
                        Bout <= bor_nxt;
                        Zero <= (r_nxt == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed plus random checks of serial_subtractor
// (WIDTH=8) against a plain-arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;

    int total = 0;
    int bad   = 0;

    // expected {Bout, Zero, Diff} per accepted operation
    logic [W+1:0] exp_q[$];
    // last published result, which must hold while an operation runs
    logic [W+1:0] held;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a),
        .B     (b),
        .busy  (busy),
        .done  (done),
        .Diff  (diff),
        .Bout  (bout),
        .Zero  (zero)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // reference model: unsigned subtraction with one extra bit for the borrow
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] t;
        t = {1'b0, x} - {1'b0, y};
        return {t[W], (t[W-1:0] == '0), t[W-1:0]};
    endfunction

    task automatic check_held(input string tag);
        check_eq({tag, "_diff"}, 32'(diff), 32'(held[W-1:0]));
        check_eq({tag, "_bout"}, 32'(bout), 32'(held[W+1]));
        check_eq({tag, "_zero"}, 32'(zero), 32'(held[W]));
    endtask

    // noise: 0 = quiet, 1 = one start pulse with A=FF,B=00 in busy cycle 2,
    // 2 = random start/A/B every busy cycle. hold keeps start high afterwards.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input int noise, input bit hold);
        logic [W+1:0] e;
        @(negedge clk);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_done", 32'(done), 32'd0);
        a = x;
        b = y;
        start = 1'b1;
        exp_q.push_back(model(x, y));
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check_eq("run_busy", 32'(busy), 32'd1);
            check_eq("run_done", 32'(done), 32'd0);
            check_held("run_hold");
            if (noise == 1) begin
                start = (i == 2) ? 1'b1 : (hold ? 1'b1 : 1'b0);
                if (i == 2) begin
                    a = 8'hFF;
                    b = 8'h00;
                end
            end else if (noise == 2) begin
                start = hold ? 1'b1 : 1'($urandom_range(0, 1));
                a = W'($urandom);
                b = W'($urandom);
            end
        end
        @(negedge clk);
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("done_busy", 32'(busy), 32'd0);
        if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            held = e;
            check_held("result");
        end
        if (!hold) start = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_diff", 32'(diff), 32'd0);
        check_eq("rst_bout", 32'(bout), 32'd0);
        check_eq("rst_zero", 32'(zero), 32'd1);
        held = {1'b0, 1'b1, {W{1'b0}}};
        exp_q.delete();
    endtask

    initial begin
        start = 1'b0;
        a     = '0;
        b     = '0;
        held  = {1'b0, 1'b1, {W{1'b0}}};
        rst_n = 1'b1;
        #2;
        apply_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // directed cases
        run_op(8'h05, 8'h03, 0, 1'b0);
        check_eq("d1_diff", 32'(diff), 32'h02);
        run_op(8'h03, 8'h05, 0, 1'b0);
        check_eq("d2_diff", 32'(diff), 32'hFE);
        check_eq("d2_bout", 32'(bout), 32'd1);
        run_op(8'h00, 8'hFF, 0, 1'b0);
        check_eq("d3_diff", 32'(diff), 32'h01);
        check_eq("d3_bout", 32'(bout), 32'd1);
        run_op(8'h5A, 8'h5A, 0, 1'b0);
        check_eq("d4_zero", 32'(zero), 32'd1);
        run_op(8'h10, 8'h01, 1, 1'b0);
        check_eq("d5_diff", 32'(diff), 32'h0F);

        // back-to-back with start held high through RUN and DONE
        run_op(8'hC3, 8'h3C, 0, 1'b1);
        run_op(8'h01, 8'h02, 0, 1'b1);
        run_op(8'h80, 8'h80, 0, 1'b0);

        // reset in the 4th busy cycle aborts the operation
        @(negedge clk);
        a = 8'h77;
        b = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("abort_busy", 32'(busy), 32'd1);
        end
        apply_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            check_eq("abort_no_done", 32'(done), 32'd0);
            check_eq("abort_no_busy", 32'(busy), 32'd0);
        end
        check_held("abort_hold");
        run_op(8'h9C, 8'h1D, 0, 1'b0);

        // randomized operations with noise on start/A/B while running
        for (int n = 0; n < 40; n++) begin
            run_op(W'($urandom), W'($urandom), 2, 1'($urandom_range(0, 1)));
        end
        start = 1'b0;
        run_op(8'hFF, 8'hFF, 2, 1'b0);
        run_op(8'h00, 8'h01, 2, 1'b0);

        @(negedge clk);
        check_eq("final_done", 32'(done), 32'd0);
        check_eq("final_busy", 32'(busy), 32'd0);
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog so the bench always ends
    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001: The module SHALL have parameter WIDTH, default 8, giving the operand and result width in bits, with legal values 2 to 32.
REQ-002: Port clk, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-003: Port rst_n, input, 1 bit, is the asynchronous, active-low reset.
REQ-004: Port start, input, 1 bit, is the request to begin one subtraction.
REQ-005: Port A, input, WIDTH bits, is the minuend; it is sampled only on the edge that accepts start.
REQ-006: Port B, input, WIDTH bits, is the subtrahend; it is sampled only on the edge that accepts start.
REQ-007: Port busy, output, 1 bit, is high while a subtraction is in progress.
REQ-008: Port done, output, 1 bit, is a single-cycle pulse marking that a result is valid.
REQ-009: Port Diff, output, WIDTH bits, is the result A-B modulo 2^WIDTH.
REQ-010: Port Bout, output, 1 bit, is the final borrow; it is 1 if and only if A<B as unsigned values.
REQ-011: Port Zero, output, 1 bit, is 1 if and only if Diff equals 0.

Function
REQ-012: The module SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013: In IDLE, start=1 on a clock edge SHALL be accepted, with these actions on that edge:
- latch A and B into internal shift registers;
- clear the borrow flop and the bit counter to 0;
- enter RUN.
REQ-014: In RUN, each edge SHALL process one operand bit, LSB first, using the full-subtractor equations:
- d = a ^ b ^ bor;
- bor_next = (~a & b) | (~(a ^ b) & bor).
REQ-015: In RUN, each edge SHALL shift d into the MSB of the internal result register, shift both operand registers right by one, and increment the counter.
REQ-016: The edge that processes bit WIDTH-1 SHALL take these actions:
- load Diff from the completed result;
- load Bout from the final borrow;
- load Zero from (result == 0);
- enter DONE.
REQ-017: busy SHALL be 1 exactly while in RUN, i.e. for the WIDTH cycles following the accepting edge.
REQ-018: done SHALL be 1 exactly while in DONE, which lasts one cycle; done therefore rises WIDTH edges after the accepting edge.
REQ-019: DONE SHALL return to IDLE unconditionally on the next edge.
REQ-020: start SHALL be ignored in RUN and DONE, and in-flight operands SHALL NOT be affected by changes on A or B.
REQ-021: Diff, Bout and Zero SHALL change only on the completing edge (REQ-016) and SHALL hold their values until the next completion; partial results SHALL never be visible on them.
REQ-022: Back-to-back operation SHALL be supported:
- start held high in the DONE cycle is ignored;
- start sampled in the following IDLE cycle is accepted, so the minimum issue interval is WIDTH+2 cycles.
REQ-023: The counter SHALL be wide enough to reach WIDTH-1 without wrap-around, for every legal WIDTH.

Reset
REQ-024: When rst_n=0, the module SHALL immediately (asynchronously) set:
- state to IDLE;
- busy=0, done=0;
- Diff=0, Bout=0, Zero=1;
- borrow flop, counter and shift registers to 0.
REQ-025: A reset asserted mid-RUN SHALL abort the operation with no done pulse and no update of the result outputs beyond the reset values.
REQ-026: After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-027: The bench SHALL cover the following directed scenarios (WIDTH=8):
- A=0x05, B=0x03, start for 1 cycle -> busy high for 8 cycles, then done for 1 cycle with Diff=0x02, Bout=0, Zero=0.
- A=0x03, B=0x05 -> Diff=0xFE, Bout=1, Zero=0.
- A=0x00, B=0xFF -> Diff=0x01, Bout=1 (borrow ripples through every bit).
- A=0x5A, B=0x5A -> Diff=0x00, Bout=0, Zero=1.
- Start with A=0x10, B=0x01; pulse start again with A=0xFF, B=0x00 while busy -> only result Diff=0x0F, Bout=0, done pulses once.
- Start, then assert rst_n=0 at the 4th busy cycle -> busy=0, done=0, Diff=0x00, Zero=1 immediately; no done pulse follows; a new start then completes correctly.
